// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator for a synchronous single-port data RAM.
// Takes single-word writes and burst reads through a valid/ready handshake.
// Drives the RAM port and returns read data with valid/last strobes, which
// hides the RAM read latency from the requester.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (accept on valid & ready)
//   req_we, req_addr, req_wdata   write one word / read start address
//   req_len                       read beats minus one
//   rd_valid, rd_data, rd_last    returned read beats, contiguous, no backpressure
//   busy                          inverse of req_ready
//   ram_we, ram_addr, ram_din     RAM command port
//   ram_dout                      RAM read data, valid RAM_LAT edges after ram_addr
module ram_access_ctrl #(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 16,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [AW-1:0] req_len,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic          busy,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ISSUE = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t               state;
   logic [AW-1:0]        beats_left;
   logic [RAM_LAT-1:0]   pipe_vld;
   logic [RAM_LAT-1:0]   pipe_last;

   // Controller: handshake, RAM command, valid pipe and read return.
   // ram_addr doubles as the burst address counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         rd_data    <= '0;
         beats_left <= '0;
         pipe_vld   <= '0;
         pipe_last  <= '0;
      end else begin
         // Token pipe tracks which RAM cycles carry requested data.
         pipe_vld[0]  <= 1'b0;
         pipe_last[0] <= 1'b0;
         for (int i = 1; i < int'(RAM_LAT); i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end

         // Capture RAM output when its token reaches the end of the pipe.
         if (pipe_vld[RAM_LAT-1]) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_dout;
            rd_last  <= pipe_last[RAM_LAT-1];
         end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  ram_addr  <= req_addr;
                  if (req_we) begin
                     ram_we  <= 1'b1;
                     ram_din <= req_wdata;
                     state   <= WRITE;
                  end else begin
                     beats_left <= req_len;
                     state      <= ISSUE;
                  end
               end
            end
            WRITE: begin
               ram_we    <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            ISSUE: begin
               pipe_vld[0]  <= 1'b1;
               pipe_last[0] <= (beats_left == '0);
               if (beats_left == '0) begin
                  state <= DRAIN;
               end else begin
                  ram_addr   <= ram_addr + AW'(1);
                  beats_left <= beats_left - AW'(1);
               end
            end
            DRAIN: begin
               // Done once the final beat is on the output and no tokens remain.
               if (rd_valid && rd_last && !(|pipe_vld)) begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
